// File: rtl/apb_master_arb.sv
// Two-requester round-robin APB master: arbitrates, runs SETUP/ACCESS, returns rdata/err.
// Optional macro APB_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT wait-state cycles.
module apb_master_arb #(
    parameter int unsigned AWIDTH  = 4,
    parameter int unsigned DWIDTH  = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_write,
    input  logic [2*AWIDTH-1:0]   req_addr,
    input  logic [2*DWIDTH-1:0]   req_wdata,
    output logic [1:0]            req_ack,
    output logic [1:0]            rsp_valid,
    output logic [DWIDTH-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [AWIDTH-1:0]     PADDR,
    output logic [DWIDTH-1:0]     PWDATA,
    input  logic [DWIDTH-1:0]     PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_t;

    state_t state;
    logic   last;
    logic   owner;
    logic   gnt_point;
    logic   gnt;
    logic   win;
    logic   done;
    logic   abort;

    if (TIMEOUT == 0 || TIMEOUT > 255) begin : g_bad_timeout
        $error("apb_master_arb: TIMEOUT must be in 1..255");
    end

`ifdef APB_TIMEOUT_EN
    localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);
    logic [7:0] wait_cnt;

    // Abort on the TIMEOUT-th consecutive wait cycle.
    assign abort = (state == StAccess) && !PREADY && (wait_cnt == WaitLast);
`else
    assign abort = 1'b0;
`endif

    assign done = (state == StAccess) && PREADY;

    always_comb begin
        gnt_point = (state == StIdle) || done;
        win       = (req_valid == 2'b11) ? ~last : req_valid[1];
        gnt       = PRESETn && gnt_point && (req_valid != 2'b00);
        req_ack   = 2'b00;
        if (gnt) begin
            req_ack = win ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state     <= StIdle;
            last      <= 1'b1;
            owner     <= 1'b0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 2'b00;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            wait_cnt  <= 8'd0;
`endif
        end else begin
            rsp_valid <= 2'b00;
            if (done || abort) begin
                rsp_valid <= owner ? 2'b10 : 2'b01;
                rsp_rdata <= (PWRITE || abort) ? '0 : PRDATA;
                rsp_err   <= abort ? 1'b1 : PSLVERR;
            end

            case (state)
                StIdle: ;
                StSetup: begin
                    state   <= StAccess;
                    PENABLE <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    wait_cnt <= 8'd0;
`endif
                end
                StAccess: begin
                    if (done || abort) begin
                        state   <= StIdle;
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                    end
`ifdef APB_TIMEOUT_EN
                    else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end
                default: state <= StIdle;
            endcase

            // A grant overrides the idle transition above, so completion chains into SETUP.
            if (gnt) begin
                state   <= StSetup;
                PSEL    <= 1'b1;
                PENABLE <= 1'b0;
                PWRITE  <= req_write[win];
                PADDR   <= win ? req_addr[2*AWIDTH-1:AWIDTH] : req_addr[AWIDTH-1:0];
                PWDATA  <= win ? req_wdata[2*DWIDTH-1:DWIDTH] : req_wdata[DWIDTH-1:0];
                owner   <= win;
                last    <= win;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_arb.sv
// Self-checking bench for apb_master_arb: directed scenarios then random traffic,
// every cycle compared against a transaction-level reference model.
module tb_apb_master_arb;

    localparam int AW  = 4;
    localparam int DW  = 8;
    localparam int TMO = 4;

    logic            PCLK = 1'b0;
    logic            PRESETn;
    logic [1:0]      req_valid, req_write, req_ack, rsp_valid;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata, PWDATA, PRDATA;
    logic            rsp_err, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [AW-1:0]   PADDR;

    int total = 0;
    int bad   = 0;

    always #5 PCLK = ~PCLK;

    apb_master_arb #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(TMO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ack(req_ack), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    // Reference model: one outstanding transfer, its age in cycles since the grant edge.
    bit            m_busy;
    int            m_age, m_waits, m_tgt, m_last;
    logic          m_wr, m_err;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rd;
    logic [1:0]    m_rv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        for (int k = 1; k <= 2; k++) begin
            if (req_valid[(m_last + k) % 2]) return (m_last + k) % 2;
        end
        return -1;
    endfunction

    function automatic bit slot_open();
        return PRESETn && (!m_busy || (m_age >= 2 && PREADY));
    endfunction

    task automatic upd(input bit g, input int p);
        bit acc;
        if (!PRESETn) begin
            m_busy = 0; m_last = 1; m_age = 0; m_waits = 0; m_tgt = 0;
            m_wr = 0; m_addr = 0; m_wdata = 0; m_rv = 0; m_rd = 0; m_err = 0;
            return;
        end
        acc  = m_busy && m_age >= 2;
        m_rv = 2'b00;
        if (acc && PREADY) begin
            m_rv = 2'b01 << m_tgt; m_rd = m_wr ? '0 : PRDATA; m_err = PSLVERR; m_busy = 0;
        end
`ifdef APB_TIMEOUT_EN
        else if (acc && m_waits + 1 == TMO) begin
            m_rv = 2'b01 << m_tgt; m_rd = '0; m_err = 1'b1; m_busy = 0;
        end
`endif
        else if (m_busy) begin
            if (acc) m_waits++;
            m_age++;
        end
        if (g) begin
            m_busy = 1; m_age = 1; m_waits = 0; m_tgt = p; m_last = p;
            m_wr = req_write[p]; m_addr = req_addr[p*AW +: AW]; m_wdata = req_wdata[p*DW +: DW];
        end
    endtask

    // One clock: check the combinational ack, advance the model, check registered outputs.
    task automatic cyc();
        int         p;
        bit         g;
        logic [1:0] ea;
        #1;
        p  = pick();
        g  = slot_open() && p >= 0;
        ea = g ? (2'b01 << p) : 2'b00;
        chk("req_ack", req_ack, ea);
        @(posedge PCLK);
        upd(g, p);
        #1;
        chk("psel", PSEL, m_busy);
        chk("penable", PENABLE, m_busy && m_age >= 2);
        chk("pwrite", PWRITE, m_wr);
        chk("paddr", PADDR, m_addr);
        chk("pwdata", PWDATA, m_wdata);
        chk("rsp_valid", rsp_valid, m_rv);
        chk("rsp_rdata", rsp_rdata, m_rd);
        chk("rsp_err", rsp_err, m_err);
        @(negedge PCLK);
    endtask

    initial begin
        PRESETn = 0; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
        PRDATA = 0; PREADY = 1; PSLVERR = 0;
        m_last = 1;
        @(negedge PCLK);
        cyc(); cyc();
        chk("reset_psel", PSEL, 1'b0);
        PRESETn = 1;

        // Single write from requester 0
        req_valid = 2'b01; req_write = 2'b01; req_addr = 8'h03; req_wdata = 16'h00A5;
        cyc();
        req_valid = 0;
        cyc(); cyc();
        chk("wr_rsp_valid", rsp_valid, 2'b01);
        chk("wr_pwdata", PWDATA, 8'hA5);
        cyc();

        // Contention straight after reset: requester 0 first
        PRESETn = 0; cyc(); PRESETn = 1;
        req_valid = 2'b11; req_write = 2'b00; req_addr = 8'h21; req_wdata = 16'h5A3C;
        cyc();
        chk("cont_first_paddr", PADDR, 4'h1);
        req_valid = 2'b10;
        cyc(); cyc();
        chk("cont_second_setup", {PSEL, PENABLE}, 2'b10);
        chk("cont_rsp0", rsp_valid, 2'b01);
        req_valid = 0;
        cyc(); cyc();
        chk("cont_rsp1", rsp_valid, 2'b10);

        // Wait states on a read from requester 1
        req_valid = 2'b10; req_write = 2'b00; req_addr = 8'h60;
        cyc();
        req_valid = 0; cyc();
        PREADY = 0; cyc(); cyc(); cyc();
        PREADY = 1; PRDATA = 8'h3C; cyc();
        chk("ws_rsp_valid", rsp_valid, 2'b10);
        chk("ws_rdata", rsp_rdata, 8'h3C);

        // Slave error then clean transfer
        req_valid = 2'b01; req_write = 2'b01; req_addr = 8'h05; req_wdata = 16'h0011;
        cyc(); req_valid = 0; cyc();
        PSLVERR = 1; cyc();
        chk("slverr_set", rsp_err, 1'b1);
        PSLVERR = 0;
        req_valid = 2'b01; cyc(); req_valid = 0; cyc(); cyc();
        chk("slverr_clear", rsp_err, 1'b0);

        // Long wait: aborts with the timeout build, otherwise keeps waiting
        req_valid = 2'b01; req_write = 2'b00; req_addr = 8'h07;
        cyc(); req_valid = 0; cyc();
        PREADY = 0;
        for (int i = 0; i < 20; i++) cyc();
`ifdef APB_TIMEOUT_EN
        chk("tmo_psel", PSEL, 1'b0);
        chk("tmo_err", rsp_err, 1'b1);
`else
        chk("wait_penable", PENABLE, 1'b1);
`endif
        PREADY = 1; PRDATA = 8'h99; cyc(); cyc();

        // Reset while in ACCESS
        req_valid = 2'b10; req_write = 2'b00; req_addr = 8'h40;
        cyc(); req_valid = 0; cyc();
        PREADY = 0; cyc();
        PRESETn = 0; cyc();
        chk("rst_acc_psel", PSEL, 1'b0);
        chk("rst_acc_rsp", rsp_valid, 2'b00);
        PRESETn = 1; PREADY = 1; req_valid = 2'b11;
        cyc();
        chk("rst_acc_regrant", PADDR, 4'h0);
        req_valid = 0; cyc(); cyc(); cyc();

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            req_valid = 2'($urandom);
            req_write = 2'($urandom);
            req_addr  = 8'($urandom);
            req_wdata = 16'($urandom);
            PREADY    = ($urandom_range(0, 3) != 0);
            PSLVERR   = ($urandom_range(0, 7) == 0);
            PRDATA    = 8'($urandom);
            PRESETn   = ($urandom_range(0, 99) != 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_master_arb.md
# apb_master_arb

Two-requester APB master that shares one APB bus between two on-chip clients and sequences the SETUP/ACCESS phases toward the register slave (address decoder plus write/read register banks). It arbitrates round-robin, latches the winning request, drives PSEL/PENABLE/PWRITE/PADDR/PWDATA, honours PREADY wait states and returns read data and PSLVERR to the granted requester.

## Interface
- AWIDTH, 4, APB address width
- DWIDTH, 8, APB data width
- TIMEOUT, 15, maximum wait-state cycles in ACCESS; used only with APB_TIMEOUT_EN; legal range 1..255
- PCLK  input  1  clock; all logic on rising edge
- PRESETn  input  1  reset; one clock; reset is synchronous and active-low
- req_valid  input  2  bit i: requester i has a transfer pending
- req_write  input  2  bit i: 1 = write, 0 = read
- req_addr  input  2*AWIDTH  requester i address in bits [i*AWIDTH +: AWIDTH]
- req_wdata  input  2*DWIDTH  requester i write data in bits [i*DWIDTH +: DWIDTH]
- req_ack  output  2  combinational one-hot grant; request fields sampled on this edge
- rsp_valid  output  2  registered one-cycle completion pulse, one-hot
- rsp_rdata  output  DWIDTH  read data, valid with rsp_valid; 0 for writes
- rsp_err  output  1  PSLVERR (or timeout) of completed transfer, valid with rsp_valid
- PSEL, PENABLE, PWRITE  output  1 each  APB control
- PADDR  output  AWIDTH; PWDATA  output  DWIDTH  APB address/write data
- PRDATA  input  DWIDTH; PREADY  input  1; PSLVERR  input  1  APB slave response

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- Grant point: state IDLE, or ACCESS with PREADY=1 (completion cycle). If any req_valid set there, one requester is chosen and req_ack[i]=1 that cycle; otherwise req_ack=0.
- Round-robin: last-granted pointer `last`; the requester other than `last` wins when both are valid; a lone valid requester always wins. Pointer updates on every grant.
- Request is consumed by req_ack; req_valid still high the following cycle is a new request. Fields need only be stable during the ack cycle.
- On grant edge: PADDR/PWDATA/PWRITE load from the granted slice, PSEL=1, PENABLE=0, state SETUP.
- SETUP -> ACCESS unconditionally: PENABLE=1.
- ACCESS, PREADY=0: hold all bus outputs.
- ACCESS, PREADY=1: completion. rsp_valid[i]=1 next cycle, rsp_rdata=PRDATA (read) or 0 (write), rsp_err=PSLVERR. Then SETUP if a new grant was made (PSEL stays 1, PENABLE 0), else IDLE (PSEL=0, PENABLE=0).
- PADDR/PWDATA/PWRITE hold their last values in IDLE.
- rsp_rdata/rsp_err hold until next completion; rsp_valid is 0 except the pulse.

## Timing
- Reset (PRESETn=0 at an edge): state IDLE, last=1 (requester 0 first), PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ack forced 0 while PRESETn=0.
- Reset mid-transfer: bus drops next cycle, no rsp_valid ever for the in-flight transfer.
- Zero-wait latency: ack cycle N, SETUP N+1, ACCESS N+2, rsp_valid N+3. Each PREADY=0 cycle adds one.
- Back-to-back sustained rate: one transfer per 2 cycles.
- Simultaneous request and completion of the same requester: new request arbitrated normally against the other.

## Configuration
- APB_TIMEOUT_EN defined: wait counter (8 bit) clears on entering ACCESS, increments per ACCESS cycle with PREADY=0; when it reaches TIMEOUT with PREADY still 0, transfer aborts: next cycle PSEL=0, PENABLE=0, state IDLE (no grant on abort cycle), rsp_valid[i]=1, rsp_err=1, rsp_rdata=0.
- Not defined: no counter; ACCESS waits for PREADY indefinitely; TIMEOUT ignored.

## Test plan
- Single write: req0 addr 4'h3, data 8'hA5, PREADY=1 -> ack cycle N, PSEL N+1, PENABLE N+2 with PWDATA=8'hA5, rsp_valid=2'b01 at N+3, rsp_err=0, rsp_rdata=0.
- Contention after reset: both req_valid=1 -> req0 granted first, req1 granted on req0's completion cycle, PSEL stays 1 with PENABLE low one cycle; rsp_valid 2'b01 then 2'b10 two cycles apart.
- Wait states: req1 read addr 4'h6, PREADY low 3 ACCESS cycles, PRDATA=8'h3C -> PENABLE high 4 cycles, rsp_rdata=8'h3C, rsp_valid=2'b10.
- Slave error: PSLVERR=1 with PREADY=1 on write -> rsp_err=1 with rsp_valid; next transfer with PSLVERR=0 -> rsp_err=0.
- Timeout (macro on, TIMEOUT=4): PREADY held 0 -> abort after 4 wait cycles, rsp_err=1, rsp_rdata=0, PSEL=0; macro off: still in ACCESS after 20 cycles, completes when PREADY rises.
- Reset in ACCESS: PRESETn=0 one edge -> all outputs at reset values next cycle, no rsp_valid; next grant goes to requester 0.
